// File: rtl/ex_muldiv_unit_pkg.sv
// Shared EX-stage encodings for the HI/LO mult/div unit and the control decoder.
package ex_muldiv_unit_pkg;

    localparam int MD_DATA_W = 32;

    typedef enum logic [2:0] {
        MD_MULT  = 3'd0,
        MD_MULTU = 3'd1,
        MD_DIV   = 3'd2,
        MD_DIVU  = 3'd3,
        MD_MTHI  = 3'd4,
        MD_MTLO  = 3'd5
    } md_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FIX  = 2'd2
    } md_state_e;

endpackage

// File: rtl/muldiv_iter.sv
// One iteration of the mult/div datapath: shift-add multiply or restoring divide.
// Accumulator is {acc_hi, acc_lo}: {partial product, multiplier} or {remainder, dividend/quotient}.
module muldiv_iter #(
    parameter int DATA_W = 32
) (
    input  logic              is_div,
    input  logic [DATA_W-1:0] acc_hi,
    input  logic [DATA_W-1:0] acc_lo,
    input  logic [DATA_W-1:0] operand,
    output logic [DATA_W-1:0] hi_nxt,
    output logic [DATA_W-1:0] lo_nxt
);

    logic [DATA_W:0] sum;
    logic [DATA_W:0] trial;

    always_comb begin
        sum    = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, operand} : '0);
        // remainder < divisor, so the shifted-in trial always fits in DATA_W+1 bits
        trial  = {acc_hi, acc_lo[DATA_W-1]} - {1'b0, operand};
        hi_nxt = sum[DATA_W:1];
        lo_nxt = {sum[0], acc_lo[DATA_W-1:1]};
        if (is_div) begin
            if (!trial[DATA_W]) begin
                hi_nxt = trial[DATA_W-1:0];
                lo_nxt = {acc_lo[DATA_W-2:0], 1'b1};
            end else begin
                hi_nxt = {acc_hi[DATA_W-2:0], acc_lo[DATA_W-1]};
                lo_nxt = {acc_lo[DATA_W-2:0], 1'b0};
            end
        end
    end

endmodule

// File: rtl/ex_muldiv_unit.sv
// EX-stage multi-cycle multiply/divide unit owning architectural HI/LO.
// Operations run on magnitudes; signs are reapplied in the single FIX cycle.
module ex_muldiv_unit
    import ex_muldiv_unit_pkg::*;
#(
    parameter int DATA_W = MD_DATA_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              op_valid,
    input  logic [2:0]        op,
    input  logic [DATA_W-1:0] op_a,
    input  logic [DATA_W-1:0] op_b,
    input  logic              mf_req,
    input  logic              abort,
    output logic [DATA_W-1:0] hi_o,
    output logic [DATA_W-1:0] lo_o,
    output logic              busy,
    output logic              stall_req,
    output logic              done
);

    localparam int CNT_W = $clog2(DATA_W);

    md_state_e         state;
    logic [CNT_W-1:0]  counter;
    logic [DATA_W-1:0] acc_hi, acc_lo, operand;
    logic              is_div, div0, neg_q, neg_r;
    logic [DATA_W-1:0] iter_hi, iter_lo;

    logic              op_is_md, op_signed, op_is_div, a_neg, b_neg, b_zero;
    logic [DATA_W-1:0] a_abs, b_abs;

    assign op_is_md  = (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
    assign op_signed = (op == MD_MULT) || (op == MD_DIV);
    assign op_is_div = (op == MD_DIV)  || (op == MD_DIVU);
    assign a_neg     = op_signed & op_a[DATA_W-1];
    assign b_neg     = op_signed & op_b[DATA_W-1];
    assign a_abs     = a_neg ? -op_a : op_a;
    assign b_abs     = b_neg ? -op_b : op_b;
    assign b_zero    = (op_b == '0);

    assign busy      = (state != ST_IDLE);
    assign stall_req = busy & (op_valid | mf_req);

    muldiv_iter #(.DATA_W(DATA_W)) u_iter (
        .is_div  (is_div),
        .acc_hi  (acc_hi),
        .acc_lo  (acc_lo),
        .operand (operand),
        .hi_nxt  (iter_hi),
        .lo_nxt  (iter_lo)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= ST_IDLE;
            counter <= '0;
            acc_hi  <= '0;
            acc_lo  <= '0;
            operand <= '0;
            is_div  <= 1'b0;
            div0    <= 1'b0;
            neg_q   <= 1'b0;
            neg_r   <= 1'b0;
            hi_o    <= '0;
            lo_o    <= '0;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            if (abort) begin
                state <= ST_IDLE;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (op_valid && op_is_md) begin
                            is_div  <= op_is_div;
                            div0    <= op_is_div & b_zero;
                            neg_q   <= a_neg ^ b_neg;
                            neg_r   <= a_neg;
                            acc_hi  <= '0;
                            // divide-by-zero keeps raw op_a so FIX can return it as HI
                            acc_lo  <= (op_is_div && b_zero) ? op_a : a_abs;
                            operand <= b_abs;
                            counter <= '0;
                            state   <= (op_is_div && b_zero) ? ST_FIX : ST_RUN;
                        end else if (op_valid && op == MD_MTHI) begin
                            hi_o <= op_a;
                        end else if (op_valid && op == MD_MTLO) begin
                            lo_o <= op_a;
                        end
                    end
                    ST_RUN: begin
                        acc_hi  <= iter_hi;
                        acc_lo  <= iter_lo;
                        counter <= counter + CNT_W'(1);
                        if (counter == CNT_W'(DATA_W-1))
                            state <= ST_FIX;
                    end
                    ST_FIX: begin
                        if (div0) begin
                            lo_o <= '1;
                            hi_o <= acc_lo;
                        end else if (is_div) begin
                            lo_o <= neg_q ? -acc_lo : acc_lo;
                            hi_o <= neg_r ? -acc_hi : acc_hi;
                        end else begin
                            {hi_o, lo_o} <= neg_q ? -{acc_hi, acc_lo} : {acc_hi, acc_lo};
                        end
                        done  <= 1'b1;
                        state <= ST_IDLE;
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Directed bench for ex_muldiv_unit: expected HI/LO queued at issue, checked on each done pulse.
module tb_ex_muldiv_unit;
    import ex_muldiv_unit_pkg::*;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         op_valid = 1'b0;
    logic [2:0]   op = 3'd0;
    logic [W-1:0] op_a = '0;
    logic [W-1:0] op_b = '0;
    logic         mf_req = 1'b0;
    logic         abort = 1'b0;
    logic [W-1:0] hi_o, lo_o;
    logic         busy, stall_req, done;

    int n_cmp = 0;
    int n_bad = 0;
    int n_done = 0;
    logic [2*W-1:0] exp_q[$];
    logic [2*W-1:0] mon_exp;

    ex_muldiv_unit #(.DATA_W(W)) dut (
        .clk(clk), .reset(reset), .op_valid(op_valid), .op(op), .op_a(op_a), .op_b(op_b),
        .mf_req(mf_req), .abort(abort), .hi_o(hi_o), .lo_o(lo_o), .busy(busy),
        .stall_req(stall_req), .done(done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!reset && done) begin
            n_done++;
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_done: got hi=%h lo=%h want no done", hi_o, lo_o);
            end else begin
                mon_exp = exp_q.pop_front();
                chk("result_hilo", {hi_o, lo_o}, mon_exp);
            end
        end
    end

    // Called just after a posedge; returns just after the accepting posedge.
    task automatic issue(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
        bit ok = 1'b0;
        op = o; op_a = a; op_b = b; op_valid = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (!stall_req) begin ok = 1'b1; break; end
        end
        if (!ok) chk("issue_timeout", 64'd1, 64'd0);
        @(posedge clk); #1;
        op_valid = 1'b0;
    endtask

    task automatic wait_done(input string name, input int exp_lat);
        int lat = 0;
        int bcnt = 0;
        for (int i = 1; i <= 80; i++) begin
            @(negedge clk);
            if (busy) bcnt++;
            if (done) begin lat = i; break; end
        end
        chk({name, "_latency"}, 64'(lat), 64'(exp_lat));
        chk({name, "_busy_cycles"}, 64'(bcnt), 64'(exp_lat - 1));
        @(negedge clk);
        chk({name, "_done_width"}, {63'd0, done}, 64'd0);
        @(posedge clk); #1;
    endtask

    initial begin
        int scnt;
        int d0;
        #1 reset = 1'b1;
        #2;
        chk("reset_state", {hi_o, lo_o}, 64'd0);
        chk("reset_ctrl", {61'd0, busy, stall_req, done}, 64'd0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        exp_q.push_back({32'hFFFFFFFF, 32'hFFFFFFEB});
        issue(MD_MULT, 32'hFFFFFFFD, 32'd7);
        wait_done("mult_neg", 34);

        exp_q.push_back({32'd2, 32'd14});
        issue(MD_DIVU, 32'd100, 32'd7);
        wait_done("divu", 34);

        exp_q.push_back({32'hFFFFFFFF, 32'hFFFFFFFD});
        issue(MD_DIV, 32'hFFFFFFF9, 32'd2);
        wait_done("div_neg", 34);

        exp_q.push_back({32'h0, 32'h80000000});
        issue(MD_DIV, 32'h80000000, 32'hFFFFFFFF);
        wait_done("div_ovf", 34);

        exp_q.push_back({32'd5, 32'hFFFFFFFF});
        issue(MD_DIVU, 32'd5, 32'd0);
        wait_done("divu_zero", 2);

        exp_q.push_back({32'hFFFFFFF9, 32'hFFFFFFFF});
        issue(MD_DIV, 32'hFFFFFFF9, 32'd0);
        wait_done("div_zero", 2);

        // MF held from the second busy cycle: stalls through FIX, then reads new value
        exp_q.push_back({32'hFFFFFFFE, 32'h00000001});
        issue(MD_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF);
        @(posedge clk); #1 mf_req = 1'b1;
        scnt = 0;
        for (int i = 0; i < 80; i++) begin
            @(negedge clk);
            if (stall_req) scnt++; else break;
        end
        chk("mf_stall_cycles", 64'(scnt), 64'd32);
        chk("mf_read", {hi_o, lo_o}, {32'hFFFFFFFE, 32'h00000001});
        @(posedge clk); #1 mf_req = 1'b0;

        op = MD_MTLO; op_a = 32'h1234; op_valid = 1'b1;
        @(negedge clk);
        chk("mtlo_no_stall", {63'd0, stall_req}, 64'd0);
        chk("mtlo_before_edge", 64'(lo_o), 64'h1);
        @(posedge clk); #1 op_valid = 1'b0;
        @(negedge clk);
        chk("mtlo_write", {hi_o, lo_o}, {32'hFFFFFFFE, 32'h00001234});
        @(posedge clk); #1;

        // MTHI arriving during RUN is held, then lands after the FIX result
        exp_q.push_back({32'd0, 32'd42});
        issue(MD_MULT, 32'd6, 32'd7);
        op = MD_MTHI; op_a = 32'hABCD; op_valid = 1'b1;
        scnt = 0;
        for (int i = 0; i < 80; i++) begin
            @(negedge clk);
            if (stall_req) scnt++; else break;
        end
        chk("mthi_stall_cycles", 64'(scnt), 64'd33);
        @(posedge clk); #1 op_valid = 1'b0;
        @(negedge clk);
        chk("mthi_after_mult", {hi_o, lo_o}, {32'h0000ABCD, 32'h0000002A});
        chk("mthi_idle", {63'd0, busy}, 64'd0);
        @(posedge clk); #1;

        d0 = n_done;
        issue(MD_MULT, 32'd5, 32'd5);
        repeat (10) @(posedge clk);
        #1 abort = 1'b1;
        @(negedge clk);
        chk("abort_pre_edge_busy", {63'd0, busy}, 64'd1);
        @(posedge clk); #1 abort = 1'b0;
        @(negedge clk);
        chk("abort_idle", {63'd0, busy}, 64'd0);
        chk("abort_hilo_kept", {hi_o, lo_o}, {32'h0000ABCD, 32'h0000002A});
        repeat (40) @(negedge clk);
        chk("abort_no_done", 64'(n_done - d0), 64'd0);
        @(posedge clk); #1;

        op = MD_MULT; op_a = 32'd3; op_b = 32'd3; op_valid = 1'b1; abort = 1'b1;
        @(posedge clk); #1 op = MD_MTLO; op_a = 32'h5555;
        @(posedge clk); #1 op_valid = 1'b0; abort = 1'b0;
        @(negedge clk);
        chk("abort_idle_not_accepted", {63'd0, busy}, 64'd0);
        chk("abort_idle_mtlo_blocked", 64'(lo_o), 64'h2A);
        @(posedge clk); #1;

        issue(MD_MULT, 32'd3, 32'd3);
        repeat (5) @(posedge clk);
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        chk("async_reset_hilo", {hi_o, lo_o}, 64'd0);
        chk("async_reset_ctrl", {61'd0, busy, stall_req, done}, 64'd0);
        @(posedge clk); #1 reset = 1'b0;
        @(negedge clk);
        chk("post_reset_idle", {63'd0, busy}, 64'd0);
        chk("queue_drained", 64'(exp_q.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/ex_muldiv_unit.md
Name: ex_muldiv_unit

Overview:
- Multi-cycle integer multiply/divide unit in the EX stage. It consumes operands and the decoded mult/div opcode registered by the ID/EX pipeline register, and owns the architectural HI/LO registers.
- It produces the values read by MFHI/MFLO.
- It raises a stall request to the hazard unit whenever a new HI/LO-touching instruction reaches EX while an operation is still in flight.

Parameters:
- DATA_W, 32, operand/HI/LO width; the iteration count equals DATA_W.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- op_valid  in  1  an HI/LO-writing instruction is in EX (already qualified by the ID/EX bubble/null)
- op  in  3  0=MULT 1=MULTU 2=DIV 3=DIVU 4=MTHI 5=MTLO; 6,7 reserved
- op_a  in  DATA_W  rs operand (after forwarding)
- op_b  in  DATA_W  rt operand (after forwarding)
- mf_req  in  1  MFHI/MFLO is in EX
- abort  in  1  kill the in-flight operation (exception flush)
- hi_o  out  DATA_W  architectural HI
- lo_o  out  DATA_W  architectural LO
- busy  out  1  state != IDLE
- stall_req  out  1  freeze PC, IF/ID and ID/EX; bubble EX/MEM
- done  out  1  one-cycle pulse on the cycle HI/LO are written by MUL/DIV

Behaviour:
- Reset (async): state=IDLE, hi_o=0, lo_o=0, busy=0, done=0, counter=0, all internal operand/sign registers 0.
- States: IDLE, RUN, FIX.
- IDLE, op_valid with op 0-3: latch |op_a|, |op_b| (signed ops only; unsigned ops pass through), neg_q=a31^b31, neg_r=a31 (signed only); counter=0. Next state is RUN, or FIX directly for DIV/DIVU with op_b==0.
- IDLE, op_valid with op 4/5: write hi_o (op 4) or lo_o (op 5) with op_a at the next edge; stay IDLE; no done pulse.
- Reserved op codes 6/7: ignored.
- RUN, multiply: shift-add, one multiplier bit per cycle, 64-bit accumulator.
- RUN, divide: restoring division, one quotient bit per cycle.
- RUN exit: after counter reaches DATA_W-1, go to FIX.
- FIX: apply sign corrections, then write HI/LO at the FIX edge, pulse done, return to IDLE.
  - Multiply: {HI,LO} = neg_q ? -product : product.
  - Divide: LO = neg_q ? -q : q; HI = neg_r ? -r : r.
- Latency: accept edge, then DATA_W RUN cycles, then 1 FIX cycle. With DATA_W=32, HI/LO are visible 34 cycles after the accept edge.
- Divide by zero (signed or unsigned): skip RUN; FIX writes LO=all ones and HI=op_a (raw value); no exception; latency 2.
- Signed overflow, 0x80000000 / -1: LO=0x80000000, HI=0. This falls out of the abs/negate path; no special case is needed.
- stall_req = busy & (op_valid | mf_req), combinational.
  - Covers FIX: MF in the same cycle as FIX stalls one cycle and reads the new value.
  - An op presented while busy is held by the stall and accepted in the first IDLE cycle.
- hi_o/lo_o change only at FIX edges or on MTHI/MTLO. MF reads them directly; there is no internal bypass.
- abort: has priority over everything.
  - Any state goes to IDLE next edge; HI/LO unchanged; no done.
  - abort while IDLE with op_valid: the op is not accepted.
- Reset mid-operation: immediate return to reset values; the partial result is discarded.
- Widths: negation is two's complement modulo 2*DATA_W (product) or DATA_W (q, r).

Decomposition:
- Shared pipeline package holds the MD_OP encodings (MULT..MTLO), the state enum (IDLE/RUN/FIX) and DATA_W. The control decoder uses the same encodings.
- One natural sub-module, muldiv_iter: the per-cycle shift-add / restore-subtract datapath step, purely combinational, selected by a mul/div flag.
- The FSM, counter, sign handling and HI/LO registers stay in ex_muldiv_unit.

Test Plan:
- MULT op_a=-3 (0xFFFFFFFD), op_b=7 → done after 34 cycles; HI=0xFFFFFFFF, LO=0xFFFFFFEB; busy=1 for 33 cycles.
- DIVU 100/7 → LO=14, HI=2. DIV -7/2 → LO=0xFFFFFFFD (-3), HI=0xFFFFFFFF (-1). DIV 0x80000000 / 0xFFFFFFFF → LO=0x80000000, HI=0.
- DIVU 5/0 → 2 cycles later LO=0xFFFFFFFF, HI=5; done pulse once.
- MULTU 0xFFFFFFFF*0xFFFFFFFF, then mf_req held from cycle 2 → stall_req=1 through the FIX cycle, 0 the next cycle; HI=0xFFFFFFFE, LO=0x00000001.
- MTLO 0x1234 while IDLE → lo_o=0x1234 next edge, stall_req=0. MTHI during RUN → stall_req=1 until IDLE, then hi_o is written and the later FIX result is unaffected (the op is serialised after).
- abort at RUN cycle 10 → IDLE next edge, HI/LO keep prior values, no done. Async reset asserted mid-RUN → all outputs 0 immediately.
